// File: rtl/mmio_harness_dev.sv
// Fuzz-harness MMIO peripheral: sticky stop/exit-code register, byte TX FIFO, free-running cycle counter.
// Optional watchdog is compiled in when MMIO_WATCHDOG_EN is defined.
module mmio_harness_dev #(
    parameter int                         MMIOAddrWidth = 31,
    parameter int                         DataWidth     = 64,
    parameter logic [MMIOAddrWidth-1:0]   BaseAddr      = 31'h1000_0000,
    parameter int                         TxDepth       = 16,
    parameter int                         WdogCycles    = 100000
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       mmio_req_i,
    input  logic                       mmio_we_i,
    input  logic [MMIOAddrWidth-1:0]   mmio_addr_i,
    input  logic [DataWidth-1:0]       mmio_wdata_i,
    input  logic [DataWidth/8-1:0]     mmio_strb_i,
    output logic [DataWidth-1:0]       mmio_rdata_o,
    output logic                       tx_valid_o,
    output logic [7:0]                 tx_data_o,
    input  logic                       tx_ready_i,
    output logic                       stop_o,
    output logic [31:0]                exit_code_o,
    output logic                       timeout_o
);

    localparam int PtrW = $clog2(TxDepth);
    localparam int CntW = PtrW + 1;

    localparam logic [1:0] OffStop   = 2'd0;
    localparam logic [1:0] OffTxData = 2'd1;
    localparam logic [1:0] OffStatus = 2'd2;
    localparam logic [1:0] OffCycles = 2'd3;

    logic                   hit;
    logic [1:0]             offset;
    logic                   wr_stop;
    logic                   push;
    logic                   pop;
    logic                   full;
    logic                   push_ok;
    logic                   ovf_set;
    logic                   ovf_clr;

    logic                   stop_q;
    logic [31:0]            exit_code_q;
    logic                   overflow_q;
    logic [63:0]            cycles_q;
    logic [CntW-1:0]        count_q;
    logic [PtrW-1:0]        rd_ptr_q;
    logic [PtrW-1:0]        wr_ptr_q;
    logic [7:0]             mem_q [TxDepth];
    logic [DataWidth-1:0]   rdata_p0;
    logic [DataWidth-1:0]   rdata_p1;
    logic [63:0]            status_word;
    logic                   unused_bits;

    assign hit    = mmio_req_i && (mmio_addr_i[MMIOAddrWidth-1:5] == BaseAddr[MMIOAddrWidth-1:5]);
    assign offset = mmio_addr_i[4:3];

    assign wr_stop = hit && mmio_we_i && (offset == OffStop) && mmio_strb_i[0] && !stop_q;
    assign push    = hit && mmio_we_i && (offset == OffTxData) && mmio_strb_i[0];
    assign ovf_clr = hit && mmio_we_i && (offset == OffStatus) && mmio_strb_i[0] && mmio_wdata_i[1];

    // A pop in the same cycle frees the slot the push lands in, so a full FIFO still accepts it.
    assign full    = (count_q == CntW'(TxDepth));
    assign pop     = tx_valid_o && tx_ready_i;
    assign push_ok = push && (!full || pop);
    assign ovf_set = push && full && !pop;

    assign unused_bits = ^{mmio_addr_i[2:0], mmio_wdata_i[DataWidth-1:32], mmio_strb_i[DataWidth/8-1:1]};

    // ---- control state: stop, overflow, counter, FIFO bookkeeping ----
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stop_q      <= 1'b0;
            exit_code_q <= 32'd0;
            overflow_q  <= 1'b0;
            cycles_q    <= 64'd0;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
        end else begin
            cycles_q <= cycles_q + 64'd1;
            if (wr_stop) begin
                stop_q      <= 1'b1;
                exit_code_q <= mmio_wdata_i[31:0];
            end
            if (ovf_set) begin
                overflow_q <= 1'b1;
            end else if (ovf_clr) begin
                overflow_q <= 1'b0;
            end
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage carries data only, so it is never reset.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= mmio_wdata_i[7:0];
        end
    end

    assign tx_valid_o = (count_q != '0);
    assign tx_data_o  = mem_q[rd_ptr_q];

`ifdef MMIO_WATCHDOG_EN
    localparam int WdW = $clog2(WdogCycles + 1);

    logic [WdW-1:0] wdog_q;
    logic           timeout_q;

    // Any hit restarts the watchdog; it freezes once the run has ended either way.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else if (!stop_q && !timeout_q) begin
            if (hit) begin
                wdog_q <= '0;
            end else begin
                wdog_q <= wdog_q + WdW'(1);
                if (wdog_q == WdW'(WdogCycles - 1)) begin
                    timeout_q <= 1'b1;
                end
            end
        end
    end

    assign timeout_o = timeout_q;
`else
    localparam int unused_wdog_cycles = WdogCycles;

    assign timeout_o = 1'b0;
`endif

    assign status_word = {48'd0, 8'(count_q), 5'd0, timeout_o, overflow_q, stop_q};

    // ---- p0: read-data select in the request cycle ----
    always_comb begin
        rdata_p0 = '0;
        if (hit && !mmio_we_i) begin
            case (offset)
                OffStop:   rdata_p0 = DataWidth'({31'd0, stop_q, exit_code_q});
                OffTxData: rdata_p0 = '0;
                OffStatus: rdata_p0 = DataWidth'(status_word);
                OffCycles: rdata_p0 = DataWidth'(cycles_q);
                default:   rdata_p0 = '0;
            endcase
        end
    end

    // ---- p1: registered read data, one cycle after the request ----
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_p1 <= '0;
        end else begin
            rdata_p1 <= rdata_p0;
        end
    end

    assign mmio_rdata_o = rdata_p1;
    assign stop_o       = stop_q;
    assign exit_code_o  = exit_code_q;

endmodule

// File: tb/tb_mmio_harness_dev.sv
// Directed, table-driven bench for mmio_harness_dev: counter, stop register, TX FIFO, overflow, reset.
// Watchdog checks are compiled in only when MMIO_WATCHDOG_EN is defined.
module tb_mmio_harness_dev;

    localparam logic [30:0] Base = 31'h1000_0000;

    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic [30:0] addr;
    logic [63:0] wdata;
    logic [7:0]  strb;
    logic [63:0] rdata;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        stop;
    logic [31:0] exit_code;
    logic        timeout;

    int passed = 0;
    int total  = 0;

    mmio_harness_dev #(
        .MMIOAddrWidth(31),
        .DataWidth(64),
        .BaseAddr(Base),
        .TxDepth(16),
        .WdogCycles(50)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .mmio_req_i(req),
        .mmio_we_i(we),
        .mmio_addr_i(addr),
        .mmio_wdata_i(wdata),
        .mmio_strb_i(strb),
        .mmio_rdata_o(rdata),
        .tx_valid_o(tx_valid),
        .tx_data_o(tx_data),
        .tx_ready_i(tx_ready),
        .stop_o(stop),
        .exit_code_o(exit_code),
        .timeout_o(timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL time_limit: bench still running, required finish");
        $fatal(1, "time limit");
    end

    typedef struct {
        logic        req;
        logic        we;
        logic        miss;
        logic [1:0]  off;
        logic [63:0] wdata;
        logic [7:0]  strb;
        logic        ready;
        logic [63:0] e_rdata;
        logic        e_valid;
        logic [7:0]  e_data;
        logic        e_stop;
        logic [31:0] e_code;
    } vec_t;

    vec_t vecs [17];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic miss, input logic [1:0] off,
                         input logic [63:0] d, input logic [7:0] s);
        req   = r;
        we    = w;
        addr  = Base + 31'({off, 3'b000}) + (miss ? 31'd32 : 31'd0);
        wdata = d;
        strb  = s;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 2'd0, 64'd0, 8'd0);
    endtask

    task automatic mmio_write(input logic [1:0] off, input logic [63:0] d, input logic [7:0] s);
        drive(1'b1, 1'b1, 1'b0, off, d, s);
        step();
        idle();
    endtask

    task automatic mmio_read(input logic [1:0] off);
        drive(1'b1, 1'b0, 1'b0, off, 64'd0, 8'd0);
        step();
        idle();
    endtask

    initial begin
        logic [7:0] drain_exp [16];

        rst      = 1'b1;
        tx_ready = 1'b0;
        idle();
        repeat (3) step();
        rst = 1'b0;

        // Cycle 0 after reset: everything cleared.
        check("reset_rdata", rdata, 64'd0);
        check("reset_tx_valid", {63'd0, tx_valid}, 64'd0);
        check("reset_stop", {63'd0, stop}, 64'd0);
        check("reset_exit_code", {32'd0, exit_code}, 64'd0);
        check("reset_timeout", {63'd0, timeout}, 64'd0);

        repeat (10) step();
        mmio_read(2'd3);
        check("cycles_at_10", rdata, 64'd10);
        step();
        check("rdata_returns_0", rdata, 64'd0);

        //           req we  miss off    wdata          strb   rdy  e_rdata                 vld  data   stp  code
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 2'd0, 64'h2A, 8'h01, 1'b0, 64'h0,              1'b0, 8'h00, 1'b1, 32'h2A};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 2'd0, 64'h55, 8'hFF, 1'b0, 64'h0,              1'b0, 8'h00, 1'b1, 32'h2A};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 2'd2, 64'h0,  8'h00, 1'b0, 64'h1,              1'b0, 8'h00, 1'b1, 32'h2A};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 2'd1, 64'h48, 8'h01, 1'b0, 64'h0,              1'b1, 8'h48, 1'b1, 32'h2A};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 2'd1, 64'h69, 8'h01, 1'b0, 64'h0,              1'b1, 8'h48, 1'b1, 32'h2A};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 2'd2, 64'h0,  8'h00, 1'b0, 64'h201,            1'b1, 8'h48, 1'b1, 32'h2A};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 2'd0, 64'h0,  8'h00, 1'b1, 64'h1_0000_002A,    1'b1, 8'h69, 1'b1, 32'h2A};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 2'd0, 64'h0,  8'h00, 1'b1, 64'h0,              1'b0, 8'h00, 1'b1, 32'h2A};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 2'd0, 64'h0,  8'h00, 1'b1, 64'h0,              1'b0, 8'h00, 1'b1, 32'h2A};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 2'd1, 64'h41, 8'hFE, 1'b1, 64'h0,              1'b0, 8'h00, 1'b1, 32'h2A};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 2'd1, 64'h42, 8'h01, 1'b1, 64'h0,              1'b1, 8'h42, 1'b1, 32'h2A};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 2'd1, 64'h43, 8'h01, 1'b1, 64'h0,              1'b1, 8'h43, 1'b1, 32'h2A};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 2'd1, 64'h0,  8'h00, 1'b0, 64'h0,              1'b1, 8'h43, 1'b1, 32'h2A};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 2'd3, 64'h0,  8'hFF, 1'b0, 64'h0,              1'b1, 8'h43, 1'b1, 32'h2A};
        vecs[14] = '{1'b1, 1'b0, 1'b1, 2'd2, 64'h0,  8'h00, 1'b0, 64'h0,              1'b1, 8'h43, 1'b1, 32'h2A};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 2'd2, 64'h0,  8'h00, 1'b0, 64'h101,            1'b1, 8'h43, 1'b1, 32'h2A};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 2'd0, 64'h0,  8'h00, 1'b1, 64'h0,              1'b0, 8'h00, 1'b1, 32'h2A};

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].req, vecs[i].we, vecs[i].miss, vecs[i].off, vecs[i].wdata, vecs[i].strb);
            tx_ready = vecs[i].ready;
            step();
            check($sformatf("vec%0d_rdata", i), rdata, vecs[i].e_rdata);
            check($sformatf("vec%0d_tx_valid", i), {63'd0, tx_valid}, {63'd0, vecs[i].e_valid});
            if (vecs[i].e_valid) begin
                check($sformatf("vec%0d_tx_data", i), {56'd0, tx_data}, {56'd0, vecs[i].e_data});
            end
            check($sformatf("vec%0d_stop", i), {63'd0, stop}, {63'd0, vecs[i].e_stop});
            check($sformatf("vec%0d_exit_code", i), {32'd0, exit_code}, {32'd0, vecs[i].e_code});
        end
        idle();
        tx_ready = 1'b0;

        // Overflow: 17 pushes into a 16-deep FIFO with the consumer stalled.
        for (int i = 0; i < 17; i++) begin
            mmio_write(2'd1, 64'(8'h10 + 8'(i)), 8'h01);
        end
        mmio_read(2'd2);
        check("ovf_status", rdata, 64'h1003);
        check("ovf_head", {56'd0, tx_data}, 64'h10);
        mmio_write(2'd2, 64'h2, 8'h01);
        mmio_read(2'd2);
        check("ovf_cleared_status", rdata, 64'h1001);

        // Full FIFO, push with a same-cycle pop: accepted, no overflow.
        tx_ready = 1'b1;
        mmio_write(2'd1, 64'h99, 8'h01);
        tx_ready = 1'b0;
        mmio_read(2'd2);
        check("full_push_pop_status", rdata, 64'h1001);

        for (int i = 0; i < 15; i++) begin
            drain_exp[i] = 8'h11 + 8'(i);
        end
        drain_exp[15] = 8'h99;
        tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain%0d_valid", i), {63'd0, tx_valid}, 64'd1);
            check($sformatf("drain%0d_data", i), {56'd0, tx_data}, {56'd0, drain_exp[i]});
            step();
        end
        check("drain_empty", {63'd0, tx_valid}, 64'd0);
        tx_ready = 1'b0;

        // Reset overrides a push in flight and restarts the counter.
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 2'd1, 64'h77, 8'h01);
        step();
        rst = 1'b0;
        idle();
        check("rst2_stop", {63'd0, stop}, 64'd0);
        check("rst2_exit_code", {32'd0, exit_code}, 64'd0);
        check("rst2_tx_valid", {63'd0, tx_valid}, 64'd0);
        check("rst2_rdata", rdata, 64'd0);
        mmio_read(2'd3);
        check("rst2_cycles0", rdata, 64'd0);
        repeat (4) step();
        mmio_read(2'd3);
        check("rst2_cycles5", rdata, 64'd5);
        mmio_read(2'd2);
        check("rst2_status", rdata, 64'd0);

`ifdef MMIO_WATCHDOG_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (49) step();
        check("wdog_c49", {63'd0, timeout}, 64'd0);
        step();
        check("wdog_c50", {63'd0, timeout}, 64'd1);
        mmio_read(2'd2);
        check("wdog_status", rdata, 64'h4);

        rst = 1'b1;
        step();
        rst = 1'b0;
        check("wdog_rst_clears", {63'd0, timeout}, 64'd0);
        repeat (49) step();
        mmio_read(2'd2);
        check("wdog_delayed_c50", {63'd0, timeout}, 64'd0);
        repeat (49) step();
        check("wdog_delayed_c99", {63'd0, timeout}, 64'd0);
        step();
        check("wdog_delayed_c100", {63'd0, timeout}, 64'd1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
